// File: rtl/ins_fetch.sv
// Instruction front end for the 8-bit teaching CPU: fetches opcode/target bytes,
// holds the instruction register and issues one decoder enable per instruction.
module ins_fetch #(
    parameter int AW       = 8,
    parameter int RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_rdata,
    input  logic          mem_ack,
    input  logic          z_flag,
    input  logic          c_flag,
    input  logic          exec_done,
    output logic [7:0]    ir,
    output logic          en,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_EXEC,
        S_FETCH_TGT,
        S_HALTED
    } state_e;

    typedef enum logic [1:0] {
        CL_EXEC,
        CL_JUMP,
        CL_NOP,
        CL_HALT
    } op_class_e;

    localparam logic [AW-1:0] PC_RST = AW'(RESET_PC);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [7:0]    ir_q, ir_d;
    logic          en_q, en_d;
    logic          halted_q, halted_d;

    op_class_e     op_class;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] jump_tgt;
    logic          taken;

    always_comb begin
        unique case (ir_q[7:4])
            4'b0011: op_class = CL_JUMP;
            4'b0111: op_class = CL_NOP;
            4'b1000: op_class = CL_HALT;
            default: op_class = CL_EXEC;
        endcase
    end

    // Increment wraps naturally at 2^AW; the target byte is truncated or zero-extended to AW.
    assign pc_inc   = pc_q + AW'(1);
    assign jump_tgt = AW'(mem_rdata);
    assign taken    = (ir_q[1:0] == 2'b00) | (ir_q[1] & c_flag) | (ir_q[0] & z_flag);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mem_rd  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_inc;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                unique case (op_class)
                    CL_JUMP: state_d = S_FETCH_TGT;
                    CL_NOP:  state_d = S_FETCH;
                    CL_HALT: state_d = S_HALTED;
                    default: state_d = S_WAIT_EXEC;
                endcase
            end
            S_WAIT_EXEC: begin
                if (exec_done) state_d = S_FETCH;
            end
            S_FETCH_TGT: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    pc_d    = taken ? jump_tgt : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // en and halted are registered from the next state so they line up with ISSUE/HALTED.
    assign en_d     = (state_d == S_ISSUE);
    assign halted_d = (state_d == S_HALTED);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pc_q     <= PC_RST;
            ir_q     <= 8'h00;
            en_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            en_q     <= en_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr = pc_q;
    assign pc       = pc_q;
    assign ir       = ir_q;
    assign en       = en_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch: program sequencing, jumps, stalls, pc wrap and mid-operation reset.
module tb_ins_fetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       z_flag = 1'b0;
    logic       c_flag = 1'b0;
    logic [7:0] mem_addr, mem_rdata, ir, pc;
    logic       mem_rd, mem_ack, exec_done, en, halted;

    logic       start_w = 1'b0;
    logic       exec_done_w = 1'b0;
    logic [7:0] mem_addr_w, rdata_w, ir_w, pc_w;
    logic       mem_rd_w, ack_w, en_w, halted_w;

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         stall_cnt;
    int         ecnt;
    bit         exec_en = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    ins_fetch #(.AW(8), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .z_flag(z_flag), .c_flag(c_flag), .exec_done(exec_done),
        .ir(ir), .en(en), .pc(pc), .halted(halted)
    );

    ins_fetch #(.AW(8), .RESET_PC(8'hFF)) dut_wrap (
        .clk(clk), .rst(rst), .start(start_w),
        .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_rdata(rdata_w), .mem_ack(ack_w),
        .z_flag(z_flag), .c_flag(c_flag), .exec_done(exec_done_w),
        .ir(ir_w), .en(en_w), .pc(pc_w), .halted(halted_w)
    );

    always #5 clk = ~clk;

    // Program memory: ack arrives after ack_delay stalled cycles of mem_rd.
    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_rd && (stall_cnt >= ack_delay);
    assign rdata_w   = mem[mem_addr_w];
    assign ack_w     = mem_rd_w;

    always @(posedge clk or posedge rst) begin
        if (rst)                     stall_cnt <= 0;
        else if (mem_rd && !mem_ack) stall_cnt <= stall_cnt + 1;
        else                         stall_cnt <= 0;
    end

    // Datapath stand-in: exec_done two cycles after each en pulse.
    always @(posedge clk or posedge rst) begin
        if (rst)            ecnt <= 0;
        else if (en)        ecnt <= 1;
        else if (ecnt == 2) ecnt <= 0;
        else if (ecnt != 0) ecnt <= ecnt + 1;
    end
    assign exec_done = exec_en && (ecnt == 2);

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        start = 1'b0;
        start_w = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the FETCH-cycle negedge that follows the start pulse.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_en(output logic [7:0] ir_v, output int cycles);
        cycles = -1;
        ir_v = 8'hxx;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (en === 1'b1) begin
                ir_v = ir;
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL reset_ir: got %h expected 00", ir); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", pc); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b expected 0", halted); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_mem_rd: got %b expected 0", mem_rd); end
    endtask

    task automatic test_program();
        logic [7:0] irv;
        int cyc;
        int bad;
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'h70; mem[2] = 8'h80;
        apply_reset();
        pulse_start();
        wait_en(irv, cyc);
        n_checks++; if (irv !== 8'h90 || cyc != 1) begin n_fail++; $display("FAIL prog_en0: got ir=%h after %0d cycles expected ir=90 after 1", irv, cyc); end
        wait_en(irv, cyc);
        n_checks++; if (irv !== 8'h70 || cyc != 4) begin n_fail++; $display("FAIL prog_en1: got ir=%h after %0d cycles expected ir=70 after 4", irv, cyc); end
        wait_en(irv, cyc);
        n_checks++; if (irv !== 8'h80 || cyc != 2) begin n_fail++; $display("FAIL prog_en2: got ir=%h after %0d cycles expected ir=80 after 2", irv, cyc); end
        @(negedge clk);
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL prog_halted: got %b expected 1", halted); end
        n_checks++; if (pc !== 8'h03) begin n_fail++; $display("FAIL prog_final_pc: got %h expected 03", pc); end
        pulse_start();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (en !== 1'b0 || mem_rd !== 1'b0 || halted !== 1'b1 || pc !== 8'h03) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic run_jump(input logic [7:0] op, input logic c, input logic z, input logic [7:0] exp_pc);
        logic [7:0] irv;
        int cyc;
        clear_mem();
        mem[0] = op; mem[1] = 8'h20; mem[2] = 8'h80; mem[8'h20] = 8'h80;
        c_flag = c; z_flag = z;
        apply_reset();
        pulse_start();
        wait_en(irv, cyc);
        n_checks++; if (irv !== op || cyc != 1) begin n_fail++; $display("FAIL jump_%h_issue: got ir=%h after %0d cycles expected ir=%h after 1", op, irv, cyc, op); end
        @(negedge clk);
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01) begin n_fail++; $display("FAIL jump_%h_tgt_read: got rd=%b addr=%h expected rd=1 addr=01", op, mem_rd, mem_addr); end
        @(negedge clk);
        n_checks++; if (pc !== exp_pc || mem_addr !== exp_pc || mem_rd !== 1'b1) begin n_fail++; $display("FAIL jump_%h_c%b_z%b_pc: got pc=%h addr=%h rd=%b expected pc=addr=%h rd=1", op, c, z, pc, mem_addr, mem_rd, exp_pc); end
        n_checks++; if (ir !== op) begin n_fail++; $display("FAIL jump_%h_ir_kept: got %h expected %h", op, ir, op); end
        c_flag = 1'b0; z_flag = 1'b0;
    endtask

    task automatic test_jump();
        run_jump(8'h33, 1'b0, 1'b1, 8'h20);
        run_jump(8'h33, 1'b1, 1'b0, 8'h20);
        run_jump(8'h32, 1'b0, 1'b1, 8'h02);
        run_jump(8'h32, 1'b1, 1'b0, 8'h20);
        run_jump(8'h31, 1'b1, 1'b0, 8'h02);
        run_jump(8'h30, 1'b0, 1'b0, 8'h20);
    endtask

    task automatic test_stall();
        int bad;
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h80;
        ack_delay = 5;
        apply_reset();
        pulse_start();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            if (mem_rd !== 1'b1 || mem_addr !== 8'h00 || ir !== 8'h00 || en !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        n_checks++; if (en !== 1'b1 || ir !== 8'h70 || pc !== 8'h01) begin n_fail++; $display("FAIL stall_issue: got en=%b ir=%h pc=%h expected en=1 ir=70 pc=01", en, ir, pc); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (en !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h01) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_single_en: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        n_checks++; if (en !== 1'b1 || ir !== 8'h80) begin n_fail++; $display("FAIL stall_second_issue: got en=%b ir=%h expected en=1 ir=80", en, ir); end
        ack_delay = 0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] irv;
        int cyc;
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h70; mem[2] = 8'h70; mem[3] = 8'h80;
        apply_reset();
        pulse_start();
        wait_en(irv, cyc);
        n_checks++; if (irv !== 8'h70 || cyc != 1) begin n_fail++; $display("FAIL b2b_first: got ir=%h after %0d expected ir=70 after 1", irv, cyc); end
        for (int k = 0; k < 3; k++) begin
            wait_en(irv, cyc);
            n_checks++; if (irv !== ((k == 2) ? 8'h80 : 8'h70) || cyc != 2) begin n_fail++; $display("FAIL b2b_rate_%0d: got ir=%h after %0d cycles expected 2 cycles", k, irv, cyc); end
        end
    endtask

    task automatic test_wrap();
        int cyc;
        clear_mem();
        mem[8'hFF] = 8'h70; mem[0] = 8'h80;
        apply_reset();
        n_checks++; if (pc_w !== 8'hFF || mem_addr_w !== 8'hFF) begin n_fail++; $display("FAIL wrap_reset_pc: got pc=%h addr=%h expected FF", pc_w, mem_addr_w); end
        @(negedge clk);
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (en_w === 1'b1) begin cyc = i; break; end
        end
        n_checks++; if (cyc != 1 || ir_w !== 8'h70 || pc_w !== 8'h00) begin n_fail++; $display("FAIL wrap_fetch: got cyc=%0d ir=%h pc=%h expected cyc=1 ir=70 pc=00", cyc, ir_w, pc_w); end
        @(negedge clk);
        n_checks++; if (mem_rd_w !== 1'b1 || mem_addr_w !== 8'h00) begin n_fail++; $display("FAIL wrap_next_read: got rd=%b addr=%h expected rd=1 addr=00", mem_rd_w, mem_addr_w); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] irv;
        int cyc;
        clear_mem();
        mem[0] = 8'h90;
        exec_en = 1'b0;
        apply_reset();
        pulse_start();
        wait_en(irv, cyc);
        @(negedge clk);
        n_checks++; if (pc !== 8'h01 || ir !== 8'h90 || en !== 1'b0) begin n_fail++; $display("FAIL mid_wait_state: got pc=%h ir=%h en=%b expected pc=01 ir=90 en=0", pc, ir, en); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_rd !== 1'b0 || en !== 1'b0 || ir !== 8'h00 || pc !== 8'h00 || halted !== 1'b0) begin n_fail++; $display("FAIL mid_wait_reset: got rd=%b en=%b ir=%h pc=%h halted=%b expected all zero", mem_rd, en, ir, pc, halted); end
        @(negedge clk);
        rst = 1'b0;
        exec_en = 1'b1;
        mem[0] = 8'h80;
        ack_delay = 3;
        pulse_start();
        @(negedge clk);
        n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_fetch_rd: got %b expected 1", mem_rd); end
        rst = 1'b1;
        #1;
        n_checks++; if (mem_rd !== 1'b0 || en !== 1'b0 || ir !== 8'h00 || pc !== 8'h00) begin n_fail++; $display("FAIL mid_fetch_reset: got rd=%b en=%b ir=%h pc=%h expected all zero", mem_rd, en, ir, pc); end
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        pulse_start();
        wait_en(irv, cyc);
        n_checks++; if (irv !== 8'h80 || cyc != 1 || pc !== 8'h01) begin n_fail++; $display("FAIL mid_restart: got ir=%h cyc=%0d pc=%h expected ir=80 cyc=1 pc=01", irv, cyc, pc); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_jump();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
